// File: rtl/column_cursor_ctrl.sv
// Column cursor and drop-request controller for a column-drop game.
// Button enable edges move the cursor or raise a drop request toward the board logic.
module column_cursor_ctrl #(
    parameter int unsigned NUM_COLS  = 7,
    parameter int unsigned COL_W     = 3,
    parameter int unsigned START_COL = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                left_en,
    input  logic                right_en,
    input  logic                drop_en,
    input  logic [NUM_COLS-1:0] col_full,
    input  logic                drop_ack,
    output logic [COL_W-1:0]    cursor_col,
    output logic                player,
    output logic                drop_req,
    output logic [COL_W-1:0]    drop_col,
    output logic                drop_player,
    output logic                reject,
    output logic                board_full
);

    typedef enum logic [1:0] {StIdle, StWaitAck, StFull} state_e;

    localparam logic [COL_W-1:0] LastCol  = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0] StartCol = COL_W'(START_COL);

    state_e           r_state, w_state;
    logic             r_prev_left, r_prev_right, r_prev_drop;
    logic [COL_W-1:0] r_cursor, w_cursor;
    logic             r_player, w_player;
    logic             r_drop_req, w_drop_req;
    logic [COL_W-1:0] r_drop_col, w_drop_col;
    logic             r_drop_player, w_drop_player;
    logic             r_reject, w_reject;
    logic             r_board_full, w_board_full;

    logic w_edge_left, w_edge_right, w_edge_drop, w_sel_full;

    assign w_edge_left  = left_en & ~r_prev_left;
    assign w_edge_right = right_en & ~r_prev_right;
    assign w_edge_drop  = drop_en & ~r_prev_drop;
    assign w_sel_full   = col_full[r_cursor];

    always_comb begin
        w_state       = r_state;
        w_cursor      = r_cursor;
        w_player      = r_player;
        w_drop_req    = r_drop_req;
        w_drop_col    = r_drop_col;
        w_drop_player = r_drop_player;
        w_reject      = 1'b0;
        w_board_full  = r_board_full;
        unique case (r_state)
            StIdle: begin
                if (&col_full) begin
                    w_state      = StFull;
                    w_board_full = 1'b1;
                end else if (w_edge_drop && !w_sel_full) begin
                    w_state       = StWaitAck;
                    w_drop_req    = 1'b1;
                    w_drop_col    = r_cursor;
                    w_drop_player = r_player;
                end else if (w_edge_drop) begin
                    w_reject = 1'b1;
                end else if (w_edge_left && w_edge_right) begin
                    w_cursor = r_cursor;
                end else if (w_edge_left) begin
                    // Explicit wrap: NUM_COLS need not be a power of two
                    w_cursor = (r_cursor == '0) ? LastCol : r_cursor - 1'b1;
                end else if (w_edge_right) begin
                    w_cursor = (r_cursor == LastCol) ? '0 : r_cursor + 1'b1;
                end
            end
            StWaitAck: begin
                if (drop_ack) begin
                    w_state    = StIdle;
                    w_drop_req = 1'b0;
                    w_player   = ~r_player;
                end
            end
            StFull: begin
                w_drop_req   = 1'b0;
                w_board_full = 1'b1;
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            // Enables held high across reset must be seen low before counting as a press
            r_prev_left   <= 1'b1;
            r_prev_right  <= 1'b1;
            r_prev_drop   <= 1'b1;
            r_cursor      <= StartCol;
            r_player      <= 1'b0;
            r_drop_req    <= 1'b0;
            r_drop_col    <= '0;
            r_drop_player <= 1'b0;
            r_reject      <= 1'b0;
            r_board_full  <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_prev_left   <= left_en;
            r_prev_right  <= right_en;
            r_prev_drop   <= drop_en;
            r_cursor      <= w_cursor;
            r_player      <= w_player;
            r_drop_req    <= w_drop_req;
            r_drop_col    <= w_drop_col;
            r_drop_player <= w_drop_player;
            r_reject      <= w_reject;
            r_board_full  <= w_board_full;
        end
    end

    assign cursor_col  = r_cursor;
    assign player      = r_player;
    assign drop_req    = r_drop_req;
    assign drop_col    = r_drop_col;
    assign drop_player = r_drop_player;
    assign reject      = r_reject;
    assign board_full  = r_board_full;

endmodule
